// File: rtl/usb_ctrl_in_collect_if.sv
// Packet-in and result-out channels of the Control IN data-stage collector.
// Signal names carry the direction as seen from the collector (slave side).
`timescale 1ns/1ps
interface usb_ctrl_in_collect_if #(
    parameter int MAX_PKT  = 8,
    parameter int MAX_XFER = 64
);
    localparam int PKT_NB_W  = $clog2(MAX_PKT) + 1;
    localparam int XFER_NB_W = $clog2(MAX_XFER) + 1;

    logic                  i_pktValid;
    logic                  o_pktReady;
    logic [8*MAX_PKT-1:0]  i_pktData;
    logic [PKT_NB_W-1:0]   i_pktData_nBytes;
    logic                  i_stall;

    logic                  o_doneValid;
    logic                  i_doneReady;
    logic [8*MAX_XFER-1:0] o_doneData;
    logic [XFER_NB_W-1:0]  o_doneNBytes;
    logic [1:0]            o_doneStatus;

    modport slave (
        input  i_pktValid, i_pktData, i_pktData_nBytes, i_stall, i_doneReady,
        output o_pktReady, o_doneValid, o_doneData, o_doneNBytes, o_doneStatus
    );

    modport master (
        output i_pktValid, i_pktData, i_pktData_nBytes, i_stall, i_doneReady,
        input  o_pktReady, o_doneValid, o_doneData, o_doneNBytes, o_doneStatus
    );
endinterface

// File: rtl/usb_ctrl_in_collect.sv
// Reassembles the data stage of one endpoint-0 control read from IN packets
// into a flat buffer and reports byte count plus completion status.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for i_start
//   ST_COLLECT | accepting IN packets until short packet, wLength or STALL
//   ST_DONE    | result presented on the done channel until consumed
`timescale 1ns/1ps
module usb_ctrl_in_collect #(
    parameter int MAX_PKT  = 8,
    parameter int MAX_XFER = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [15:0] i_wLength,
    output logic        o_busy,
    usb_ctrl_in_collect_if.slave io_bus
);
    localparam int PW = $clog2(MAX_PKT) + 1;
    localparam int XW = $clog2(MAX_XFER) + 1;

    localparam logic [1:0] ST_OK     = 2'd0;
    localparam logic [1:0] ST_STALL  = 2'd1;
    localparam logic [1:0] ST_BABBLE = 2'd2;
    localparam logic [1:0] ST_TRUNC  = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [15:0]           r_wlen;
    logic [15:0]           r_rx_cnt;
    logic [8*MAX_XFER-1:0] r_buf;
    logic [XW-1:0]         r_cnt;
    logic [1:0]            r_status;
    logic                  r_trunc;

    logic [15:0]           w_n;
    logic [15:0]           w_rem;
    logic                  w_babble;
    logic [15:0]           w_take;
    logic [15:0]           w_sum;
    logic                  w_drop;
    logic [XW-1:0]         w_cnt_nxt;
    logic [15:0]           w_rx_nxt;
    logic                  w_last;
    logic                  w_trunc_nxt;
    logic                  w_accept;
    logic [8*MAX_XFER-1:0] w_buf_nxt;

    // Oversized length fields are clamped to one max packet; anything past
    // the remaining wLength is babble and only the wanted part is kept.
    assign w_n         = (io_bus.i_pktData_nBytes > PW'(MAX_PKT)) ? 16'(MAX_PKT)
                                                                  : 16'(io_bus.i_pktData_nBytes);
    assign w_rem       = r_wlen - r_rx_cnt;
    assign w_babble    = (w_n > w_rem);
    assign w_take      = w_babble ? w_rem : w_n;
    assign w_sum       = 16'(r_cnt) + w_take;
    assign w_drop      = (w_sum > 16'(MAX_XFER));
    assign w_cnt_nxt   = w_drop ? XW'(MAX_XFER) : XW'(w_sum);
    assign w_rx_nxt    = r_rx_cnt + w_take;
    assign w_trunc_nxt = r_trunc | w_drop;
    assign w_last      = w_babble || (w_n < 16'(MAX_PKT)) || (w_rx_nxt == r_wlen);

    assign o_busy              = (r_state != ST_IDLE);
    assign io_bus.o_doneData   = r_buf;
    assign io_bus.o_doneNBytes = r_cnt;
    assign io_bus.o_doneStatus = r_status;

    // Merge the taken packet bytes at the current fill offset, dropping any
    // that would fall off the end of the buffer.
    always_comb begin
        w_buf_nxt = r_buf;
        for (int k = 0; k < MAX_PKT; k++) begin
            if ((16'(k) < w_take) && ((int'(r_cnt) + k) < MAX_XFER)) begin
                w_buf_nxt[(int'(r_cnt) + k)*8 +: 8] = io_bus.i_pktData[k*8 +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; STALL takes priority over a packet.
    always_comb begin
        w_state_nxt        = r_state;
        w_accept           = 1'b0;
        io_bus.o_pktReady  = 1'b0;
        io_bus.o_doneValid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_wLength == 16'd0) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                io_bus.o_pktReady = 1'b1;
                if (io_bus.i_stall) begin
                    w_state_nxt = ST_DONE;
                end else if (io_bus.i_pktValid) begin
                    w_accept = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                io_bus.o_doneValid = 1'b1;
                if (io_bus.i_doneReady) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Transfer context and reassembly buffer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wlen   <= '0;
            r_rx_cnt <= '0;
            r_buf    <= '0;
            r_cnt    <= '0;
            r_status <= ST_OK;
            r_trunc  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_wlen   <= i_wLength;
                        r_rx_cnt <= '0;
                        r_buf    <= '0;
                        r_cnt    <= '0;
                        r_status <= ST_OK;
                        r_trunc  <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (io_bus.i_stall) begin
                        r_status <= ST_STALL;
                    end else if (w_accept) begin
                        r_buf    <= w_buf_nxt;
                        r_cnt    <= w_cnt_nxt;
                        r_rx_cnt <= w_rx_nxt;
                        r_trunc  <= w_trunc_nxt;
                        if (w_last) begin
                            r_status <= w_babble    ? ST_BABBLE :
                                        w_trunc_nxt ? ST_TRUNC  : ST_OK;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_ctrl_in_collect.sv
// Randomised and directed bench for usb_ctrl_in_collect with a queue-based
// scoreboard fed by a transfer-level reference model.
`timescale 1ns/1ps
module tb_usb_ctrl_in_collect;
    localparam int MP = 8;
    localparam int MX = 64;
    localparam int W  = 8*MX;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] wlen_in = '0;
    logic        busy;

    usb_ctrl_in_collect_if #(.MAX_PKT(MP), .MAX_XFER(MX)) bus ();

    usb_ctrl_in_collect #(.MAX_PKT(MP), .MAX_XFER(MX)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_wLength (wlen_in),
        .o_busy    (busy),
        .io_bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           nb;
        int           st;
    } exp_t;

    int            n_chk = 0;
    int            n_fail = 0;
    exp_t          sb[$];
    logic [8*MP-1:0] pd[20];
    int            pl[20];
    bit            hold_low = 1'b0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: walk the packet list applying the transfer rules on a byte queue.
    task automatic model(input int wl, input int np, input int si,
                         output exp_t e, output int ncyc);
        byte unsigned q[$];
        int rx, st, n, rem, take;
        rx = 0; st = -1; ncyc = 0;
        if (wl == 0) st = 0;
        for (int i = 0; i < np && st < 0; i++) begin
            ncyc = i + 1;
            if (i == si) begin
                st = 1;
            end else begin
                n    = (pl[i] > MP) ? MP : pl[i];
                rem  = wl - rx;
                take = (n > rem) ? rem : n;
                for (int k = 0; k < take; k++) q.push_back(pd[i][k*8 +: 8]);
                rx += take;
                if (n > rem) st = 2;
                else if (n < MP || rx == wl) st = (q.size() > MX) ? 3 : 0;
            end
        end
        e.nb   = (q.size() > MX) ? MX : q.size();
        e.st   = st;
        e.data = '0;
        for (int k = 0; k < e.nb; k++) e.data[k*8 +: 8] = q[k];
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy",      W'(busy), 0);
        chk("rst_pktReady",  W'(bus.o_pktReady), 0);
        chk("rst_doneValid", W'(bus.o_doneValid), 0);
        chk("rst_doneData",  bus.o_doneData, 0);
        chk("rst_doneNBytes", W'(bus.o_doneNBytes), 0);
        chk("rst_doneStatus", W'(bus.o_doneStatus), 0);
    endtask

    task automatic run_xfer(input int wl, input int np, input int si, input bit rnd);
        exp_t e;
        int   ncyc;
        int   t;
        model(wl, np, si, e, ncyc);
        sb.push_back(e);
        start = 1'b1; wlen_in = 16'(wl);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", W'(busy), 1);
        for (int i = 0; i < ncyc; i++) begin
            if (rnd) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.i_pktValid = 1'b0;
                    bus.i_pktData  = {$urandom, $urandom};
                    @(posedge clk); #1;
                end
            end
            chk("pkt_ready", W'(bus.o_pktReady), 1);
            start   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            wlen_in = 16'($urandom);
            bus.i_pktValid       = (i == si && rnd) ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.i_pktData        = pd[i];
            bus.i_pktData_nBytes = 4'(pl[i]);
            bus.i_stall          = (i == si);
            @(posedge clk); #1;
            bus.i_pktValid = 1'b0;
            bus.i_stall    = 1'b0;
            start          = 1'b0;
            if (i < ncyc - 1) chk("no_early_done", W'(bus.o_doneValid), 0);
        end
        chk("done_valid_timing", W'(bus.o_doneValid), 1);
        if (hold_low) begin
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                chk("done_held", W'(bus.o_doneValid), 1);
            end
            hold_low = 1'b0;
        end
        t = 0;
        while (busy && t < 100) begin
            chk("ready_in_done", W'(bus.o_pktReady), 0);
            start          = 1'($urandom_range(0, 1));
            wlen_in        = 16'($urandom);
            bus.i_pktValid = 1'($urandom_range(0, 1));
            bus.i_stall    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            t++;
        end
        start = 1'b0; bus.i_pktValid = 1'b0; bus.i_stall = 1'b0;
        chk("idle_after_handshake", W'(busy), 0);
    endtask

    task automatic fill_full(input int np, input int seed);
        for (int i = 0; i < np; i++) begin
            pl[i] = 8;
            for (int k = 0; k < MP; k++) pd[i][k*8 +: 8] = 8'(seed + i*8 + k);
        end
    endtask

    // Result consumer: random back-pressure, or held off on request.
    initial begin
        bus.i_doneReady = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.i_doneReady = hold_low ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: pop and compare on every done handshake; check hold stability.
    logic         pv = 1'b0, pr = 1'b0;
    logic [W-1:0] p_dat;
    int           p_nb, p_st;
    exp_t         mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("stable_valid",  W'(bus.o_doneValid), 1);
                chk("stable_data",   bus.o_doneData, p_dat);
                chk("stable_nbytes", W'(bus.o_doneNBytes), W'(p_nb));
                chk("stable_status", W'(bus.o_doneStatus), W'(p_st));
            end
            if (bus.o_doneValid && bus.i_doneReady) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_data",   bus.o_doneData, mon_e.data);
                    chk("done_nbytes", W'(bus.o_doneNBytes), W'(mon_e.nb));
                    chk("done_status", W'(bus.o_doneStatus), W'(mon_e.st));
                end
            end
            pv    = bus.o_doneValid;
            pr    = bus.i_doneReady;
            p_dat = bus.o_doneData;
            p_nb  = int'(bus.o_doneNBytes);
            p_st  = int'(bus.o_doneStatus);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wl, np, si;
        bus.i_pktValid = 1'b0; bus.i_pktData = '0;
        bus.i_pktData_nBytes = '0; bus.i_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Device descriptor 8+8+2, with the consumer held off for 5 cycles.
        fill_full(3, 0);
        pd[0][7:0] = 8'h12; pd[0][15:8] = 8'h01; pl[2] = 2;
        hold_low = 1'b1;
        run_xfer(18, 3, -1, 1'b0);

        // Config descriptor ended by a zero-length packet.
        fill_full(5, 8'h40); pl[4] = 0;
        run_xfer(16'hFFFF, 5, -1, 1'b0);

        // Exactly wLength, no ZLP.
        fill_full(4, 8'h60);
        run_xfer(32, 4, -1, 1'b0);

        // STALL together with a second valid packet.
        fill_full(2, 8'h80);
        run_xfer(16'hFFFF, 2, 1, 1'b0);

        // Babble.
        fill_full(2, 8'h90);
        run_xfer(10, 2, -1, 1'b0);

        // Truncation: 75 bytes into a 64-byte buffer.
        fill_full(10, 8'h05); pl[9] = 3;
        run_xfer(16'hFFFF, 10, -1, 1'b0);

        // Zero wLength.
        run_xfer(0, 0, -1, 1'b0);

        // Reset mid-COLLECT abandons the transfer.
        fill_full(2, 8'hA0);
        start = 1'b1; wlen_in = 16'hFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.i_pktValid = 1'b1; bus.i_pktData = pd[i]; bus.i_pktData_nBytes = 4'd8;
            @(posedge clk); #1;
        end
        bus.i_pktValid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Normal transfer right after the reset.
        fill_full(3, 8'hB0); pl[2] = 5;
        run_xfer(40, 3, -1, 1'b0);

        // Randomised transfers.
        for (int x = 0; x < 40; x++) begin
            case ($urandom_range(0, 4))
                0:       wl = (x % 8 == 0) ? 0 : int'($urandom_range(1, 40));
                1:       wl = int'($urandom_range(1, 40));
                2:       wl = 16'hFFFF;
                3:       wl = 8 * int'($urandom_range(1, 9));
                default: wl = int'($urandom_range(1, 100));
            endcase
            np = int'($urandom_range(1, 12));
            for (int i = 0; i < np; i++) begin
                pd[i] = {$urandom, $urandom};
                pl[i] = ($urandom_range(0, 3) != 0) ? 8 : int'($urandom_range(0, 15));
            end
            pl[np-1] = int'($urandom_range(0, 7));
            si = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, np - 1)) : -1;
            if ($urandom_range(0, 9) == 0) hold_low = 1'b1;
            run_xfer(wl, np, si, 1'b1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", W'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
